// File: rtl/iter_div.sv
// Radix-2 restoring divider: quotient and remainder together, fixed 33-cycle latency.
// Signed operands are divided as magnitudes, and the results are sign-corrected on the way out.
module iter_div #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             div_en,
    input  logic             div_signed,
    input  logic [WIDTH-1:0] x,
    input  logic [WIDTH-1:0] y,
    output logic [WIDTH-1:0] s,
    output logic [WIDTH-1:0] r,
    output logic             complete
);
    localparam int CW = $clog2(WIDTH);

    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

    state_t           state_q;
    logic [CW-1:0]    cnt_q;
    logic [WIDTH-1:0] dvd_q;
    logic [WIDTH-1:0] dvs_q;
    logic [WIDTH:0]   rem_q;
    logic [WIDTH-1:0] s_q;
    logic [WIDTH-1:0] r_q;
    logic             complete_q;
    logic             neg_x_q;
    logic             neg_q_q;
    logic             dz_q;

    logic [WIDTH-1:0] abs_x;
    logic [WIDTH-1:0] abs_y;
    logic [WIDTH:0]   shifted;
    logic [WIDTH+1:0] diff;
    logic [WIDTH:0]   rem_d;
    logic [WIDTH-1:0] dvd_d;
    logic [WIDTH-1:0] s_d;
    logic [WIDTH-1:0] r_d;

    always_comb begin
        abs_x = (div_signed && x[WIDTH-1]) ? -x : x;
        abs_y = (div_signed && y[WIDTH-1]) ? -y : y;
        shifted = {rem_q[WIDTH-1:0], dvd_q[WIDTH-1]};
        // One extra bit above the remainder width so the borrow shows up as the sign bit.
        diff = {1'b0, shifted} - {2'b00, dvs_q};
        if (diff[WIDTH+1]) begin
            rem_d = shifted;
            dvd_d = {dvd_q[WIDTH-2:0], 1'b0};
        end else begin
            rem_d = diff[WIDTH:0];
            dvd_d = {dvd_q[WIDTH-2:0], 1'b1};
        end
        // A zero divisor leaves an all-ones quotient, and that must not be negated.
        if (dz_q) begin
            s_d = '1;
        end else begin
            s_d = neg_q_q ? -dvd_d : dvd_d;
        end
        r_d = neg_x_q ? -rem_d[WIDTH-1:0] : rem_d[WIDTH-1:0];
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            dvd_q      <= '0;
            dvs_q      <= '0;
            rem_q      <= '0;
            s_q        <= '0;
            r_q        <= '0;
            complete_q <= 1'b0;
            neg_x_q    <= 1'b0;
            neg_q_q    <= 1'b0;
            dz_q       <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    complete_q <= 1'b0;
                    if (div_en) begin
                        dvd_q   <= abs_x;
                        dvs_q   <= abs_y;
                        neg_x_q <= div_signed & x[WIDTH-1];
                        neg_q_q <= div_signed & (x[WIDTH-1] ^ y[WIDTH-1]);
                        dz_q    <= (y == '0);
                        rem_q   <= '0;
                        cnt_q   <= '0;
                        state_q <= CALC;
                    end
                end
                CALC: begin
                    if (!div_en) begin
                        state_q <= IDLE;
                    end else begin
                        rem_q <= rem_d;
                        dvd_q <= dvd_d;
                        cnt_q <= cnt_q + CW'(1);
                        if (cnt_q == CW'(WIDTH - 1)) begin
                            s_q        <= s_d;
                            r_q        <= r_d;
                            complete_q <= 1'b1;
                            state_q    <= DONE;
                        end
                    end
                end
                DONE: begin
                    complete_q <= 1'b0;
                    state_q    <= IDLE;
                end
                default: begin
                    complete_q <= 1'b0;
                    state_q    <= IDLE;
                end
            endcase
        end
    end

    assign s        = s_q;
    assign r        = r_q;
    assign complete = complete_q;
endmodule

// File: tb/tb_iter_div.sv
// Directed and random checks of iter_div against an arithmetic reference model.
module tb_iter_div;
    logic        clk = 1'b0;
    logic        resetn = 1'b0;
    logic        div_en = 1'b0;
    logic        div_signed = 1'b0;
    logic [31:0] x = '0;
    logic [31:0] y = '0;
    logic [31:0] s;
    logic [31:0] r;
    logic        complete;

    int passed = 0;
    int total = 0;

    iter_div #(.WIDTH(32)) dut (
        .clk(clk), .resetn(resetn), .div_en(div_en), .div_signed(div_signed),
        .x(x), .y(y), .s(s), .r(r), .complete(complete)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    function automatic void ref_div(input logic [31:0] a, input logic [31:0] b, input logic sg,
                                    output logic [31:0] q, output logic [31:0] rm);
        int sa;
        int sb;
        sa = a;
        sb = b;
        if (b == 32'd0) begin
            q = 32'hFFFF_FFFF;
            rm = a;
        end else if (!sg) begin
            q = a / b;
            rm = a % b;
        end else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
            q = 32'h8000_0000;
            rm = 32'd0;
        end else begin
            q = sa / sb;
            rm = sa % sb;
        end
    endfunction

    task automatic run_op(input logic [31:0] a, input logic [31:0] b, input logic sg, input string tag);
        logic [31:0] es;
        logic [31:0] er;
        int n;
        bit seen;
        ref_div(a, b, sg, es, er);
        @(negedge clk);
        x = a; y = b; div_signed = sg; div_en = 1'b1;
        n = 0;
        seen = 0;
        while (!seen && n < 100) begin
            @(negedge clk);
            n++;
            if (complete === 1'b1) seen = 1;
        end
        chk({tag, ":latency"}, 32'(n), 32'd33);
        chk({tag, ":s"}, s, es);
        chk({tag, ":r"}, r, er);
        div_en = 1'b0;
        @(negedge clk);
        chk({tag, ":cplt_low"}, {31'd0, complete}, 32'd0);
    endtask

    initial begin
        int cplt_cnt;
        int hits[$];
        bit dbl;
        bit prev;
        logic [31:0] ra;
        logic [31:0] rb;

        repeat (3) @(negedge clk);
        chk("rst_s", s, 32'd0);
        chk("rst_r", r, 32'd0);
        chk("rst_cplt", {31'd0, complete}, 32'd0);
        resetn = 1'b1;

        run_op(32'd100, 32'd7, 1'b0, "u100_7");
        run_op(32'hFFFF_FFF9, 32'd2, 1'b1, "sm7_2");
        run_op(32'd7, 32'hFFFF_FFFE, 1'b1, "s7_m2");
        run_op(32'h8000_0000, 32'hFFFF_FFFF, 1'b1, "s_ovf");
        run_op(32'h1234_5678, 32'd0, 1'b1, "s_dz");
        run_op(32'hFFFF_FFFF, 32'd1, 1'b0, "u_max_1");
        run_op(32'h8765_4321, 32'd0, 1'b0, "u_dz");
        run_op(32'hFFFF_FFF0, 32'd0, 1'b1, "s_dz_neg");

        for (int i = 0; i < 16; i++) begin
            ra = $urandom;
            case (i % 4)
                0: rb = $urandom;
                1: rb = $urandom_range(1, 300);
                2: rb = 32'hFFFF_FFFF - $urandom_range(0, 300);
                default: rb = {16'd0, 16'($urandom)};
            endcase
            run_op(ra, rb, 1'(i % 2), $sformatf("rnd%0d", i));
        end

        // The request is dropped while the divider is still in CALC (counter 10), so no result may come out.
        run_op(32'd13, 32'd4, 1'b0, "pre_abort");
        cplt_cnt = 0;
        @(negedge clk);
        x = 32'd50; y = 32'd5; div_signed = 1'b0; div_en = 1'b1;
        repeat (11) begin
            @(negedge clk);
            if (complete === 1'b1) cplt_cnt++;
        end
        div_en = 1'b0;
        repeat (40) begin
            @(negedge clk);
            if (complete === 1'b1) cplt_cnt++;
        end
        chk("abort_no_cplt", 32'(cplt_cnt), 32'd0);
        chk("abort_s_hold", s, 32'd3);
        chk("abort_r_hold", r, 32'd1);
        run_op(32'd9, 32'd4, 1'b0, "after_abort");

        // Holding div_en high continuously: results should appear at cycles 33 and 67.
        @(negedge clk);
        x = 32'd1000; y = 32'd10; div_signed = 1'b0; div_en = 1'b1;
        dbl = 0;
        prev = 0;
        for (int n = 1; n <= 70; n++) begin
            @(negedge clk);
            if (complete === 1'b1) begin
                hits.push_back(n);
                chk($sformatf("b2b_s@%0d", n), s, 32'd100);
                chk($sformatf("b2b_r@%0d", n), r, 32'd0);
                if (prev) dbl = 1;
            end
            prev = (complete === 1'b1);
        end
        div_en = 1'b0;
        chk("b2b_count", 32'(hits.size()), 32'd2);
        chk("b2b_first", (hits.size() > 0) ? 32'(hits[0]) : 32'hFFFF_FFFF, 32'd33);
        chk("b2b_second", (hits.size() > 1) ? 32'(hits[1]) : 32'hFFFF_FFFF, 32'd67);
        chk("b2b_no_double", {31'd0, dbl}, 32'd0);
        repeat (3) @(negedge clk);

        // Start from s=2, r=1 so the asynchronous clear is visible on both result registers.
        run_op(32'd9, 32'd4, 1'b0, "pre_reset");
        @(negedge clk);
        x = 32'd1000; y = 32'd7; div_signed = 1'b0; div_en = 1'b1;
        repeat (21) @(negedge clk);
        #2;
        resetn = 1'b0;
        #1;
        chk("mid_rst_s", s, 32'd0);
        chk("mid_rst_r", r, 32'd0);
        chk("mid_rst_cplt", {31'd0, complete}, 32'd0);
        x = 32'd3; y = 32'd3; div_en = 1'b0;
        @(negedge clk);
        resetn = 1'b1;
        run_op(32'd3, 32'd3, 1'b0, "after_reset");

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule

// File: doc/iter_div.md
Name: iter_div

Overview:
- Multi-cycle radix-2 restoring divider. It is the responder behind the ALU's div/mod request interface (div_en / div_signed / operands in, quotient / remainder / complete out).
- Serves the DIV.W, DIV.WU, MOD.W and MOD.WU instructions in the EX stage.
- The ALU holds div_en and the operands stable until complete is seen. The divider computes quotient and remainder together in a fixed 33-cycle latency.

Parameters:
- WIDTH, 32, operand/result width. The ALU instantiates it at 32 only.

Ports:
- clk  input  1  system clock, rising edge.
- resetn  input  1  asynchronous active-low reset.
- div_en  input  1  request. Held high by the ALU while a div/mod op occupies EX.
- div_signed  input  1  1 = signed (DIV.W/MOD.W), 0 = unsigned.
- x  input  WIDTH  dividend, stable while div_en=1.
- y  input  WIDTH  divisor, stable while div_en=1.
- s  output  WIDTH  quotient, registered.
- r  output  WIDTH  remainder, registered.
- complete  output  1  one-cycle pulse; s/r are valid in this cycle.

Behaviour:
- Reset (async, resetn=0):
  - state=IDLE, s=0, r=0, complete=0, counter=0, internal registers=0.
  - Reset mid-operation aborts immediately; no complete is produced.
- States: IDLE, CALC, DONE.
- IDLE:
  - On a clk edge with div_en=1, latch |x|, |y|, the sign of x, the sign of (x xor y), div_signed, and the flag y==0.
  - Absolute values are taken only when div_signed=1; otherwise the raw operands are used.
  - |0x80000000| = 0x80000000, treated unsigned.
  - Clear the partial remainder, set counter=0, go to CALC.
- CALC, one iteration per cycle, 32 cycles (counter 0..31):
  - Form the trial remainder from {rem, next dividend MSB} minus |y| in a (WIDTH+1)-bit subtract.
  - Non-negative: keep the difference and shift in quotient bit 1. Otherwise keep the shifted value and shift in 0.
  - When counter=31, go to DONE and write the sign-corrected results into s and r.
- Sign correction (signed only):
  - Quotient is negated if sign(x) != sign(y).
  - Remainder is negated if x is negative; remainder sign always follows the dividend.
- DONE:
  - complete=1 for exactly this one cycle, then go to IDLE.
  - If div_en is still high in the following IDLE cycle, a new operation starts. Back-to-back requests are therefore spaced 34 cycles apart.
- Latency:
  - div_en first sampled high in IDLE at edge E0.
  - CALC occupies the cycles after edges E1..E32; the results register at E32.
  - complete is high in the cycle after edge E33-1, i.e. 33 cycles after the request cycle.
- Result hold: s and r keep their values after complete until the next DONE or a reset. They are not cleared on a new start.
- Abort: if div_en=0 in any CALC cycle (pipeline flush), go to IDLE next edge. No complete; s and r are unchanged.
- div_en=0 in IDLE: no action, complete=0.
- Divide by zero (fixed, deterministic; sign correction is bypassed):
  - Unsigned: s=0xFFFFFFFF, r=x.
  - Signed: s=0xFFFFFFFF, r=x.
- Signed overflow 0x80000000 / 0xFFFFFFFF: s=0x80000000, r=0. This falls out of the magnitude path; no special case is needed.
- Operands are only sampled at the start; changes during CALC are ignored.
- complete never asserts while resetn=0 or in IDLE/CALC.
- Width rules:
  - Remainder datapath WIDTH+1 bits; quotient shift register WIDTH bits; counter 5 bits ($clog2(WIDTH)).
  - Negation is two's complement, modulo 2^WIDTH.

Test Plan:
- Unsigned divide: x=100, y=7, div_signed=0, div_en held -> complete exactly 33 cycles after the request cycle with s=14, r=2. complete is low the cycle after.
- Signed mixed signs: x=0xFFFFFFF9 (-7), y=2, div_signed=1 -> s=0xFFFFFFFD (-3), r=0xFFFFFFFF (-1). Separately x=7, y=0xFFFFFFFE -> s=0xFFFFFFFD, r=1.
- Edge operands, signed:
  - 0x80000000 / 0xFFFFFFFF -> s=0x80000000, r=0.
  - x=0x12345678, y=0 -> s=0xFFFFFFFF, r=0x12345678.
  - Unsigned 0xFFFFFFFF / 1 -> s=0xFFFFFFFF, r=0.
- Abort: start 50/5, drop div_en at CALC cycle 10, re-raise with 9/4 two cycles later -> no complete from the first request. complete arrives 33 cycles after the re-raise with s=2, r=1.
- Back-to-back: div_en held continuously with 1000/10 -> complete pulses at cycles 33 and 67, both with s=100, r=0. complete is never high for two consecutive cycles.
- Reset mid-operation: assert resetn=0 asynchronously at CALC cycle 20 -> s=0, r=0, complete=0 immediately. After release with div_en=1 and 3/3, s=1, r=0 arrives 33 cycles later.
